// File: rtl/bsg_imul_pkg.sv
// bsg_imul_pkg: shared FSM state encoding and iteration sizing helpers for the iterative multiplier
package bsg_imul_pkg;

    typedef enum logic [2:0] {IDLE, NEG, CALC, NEG_R, DONE} state_e;

    function automatic int iter_count(input int w, input int b);
        return w / b;
    endfunction

    function automatic int cnt_width(input int w, input int b);
        return $clog2(w / b + 1);
    endfunction

endpackage

// File: rtl/bsg_imul_radix_pp.sv
// bsg_imul_radix_pp: unsigned partial product of one multiplier digit and the shifted multiplicand
// mcand_i: 2*width_p multiplicand, digit_i: bits_per_iter_p multiplier digit, pp_o: product truncated to 2*width_p
module bsg_imul_radix_pp #(
    parameter int width_p         = 32,
    parameter int bits_per_iter_p = 1
) (
    input  logic [2*width_p-1:0]       mcand_i,
    input  logic [bits_per_iter_p-1:0] digit_i,
    output logic [2*width_p-1:0]       pp_o
);

    assign pp_o = mcand_i * (2*width_p)'(digit_i);

endmodule

// File: rtl/bsg_imul_iterative_radix.sv
// bsg_imul_iterative_radix: sign-magnitude iterative multiplier retiring bits_per_iter_p multiplier bits per cycle
// clk_i/reset_i: clock and async active-high reset; v_i/ready_and_o: request handshake;
// opA_i/opB_i, signed_opA_i/signed_opB_i, gets_high_part_i: operands and mode;
// v_o/result_o/yumi_i: result handshake, result_o is the selected product half
module bsg_imul_iterative_radix
    import bsg_imul_pkg::*;
#(
    parameter int width_p         = 32,
    parameter int bits_per_iter_p = 1,
    parameter int early_exit_p    = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_and_o,
    input  logic [width_p-1:0] opA_i,
    input  logic [width_p-1:0] opB_i,
    input  logic               signed_opA_i,
    input  logic               signed_opB_i,
    input  logic               gets_high_part_i,
    output logic               v_o,
    output logic [width_p-1:0] result_o,
    input  logic               yumi_i
);

    localparam int n_lp     = iter_count(width_p, bits_per_iter_p);
    localparam int cnt_w_lp = cnt_width(width_p, bits_per_iter_p);

    if (width_p % bits_per_iter_p != 0) begin : g_bad_radix
        $error("width_p must be a multiple of bits_per_iter_p");
    end

    state_e                 state_q;
    logic [2*width_p-1:0]   a_q, acc_q, a_mag_d, pp;
    logic [width_p-1:0]     b_q, b_mag_d, b_shift_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic                   neg_q, hi_q, sa_q, sb_q, sa_eff, sb_eff, last_d;

    bsg_imul_radix_pp #(
        .width_p         (width_p),
        .bits_per_iter_p (bits_per_iter_p)
    ) pp_u (
        .mcand_i (a_q),
        .digit_i (b_q[bits_per_iter_p-1:0]),
        .pp_o    (pp)
    );

    // Operands live as magnitudes during CALC; the sign is reapplied to the whole product in NEG_R.
    assign sa_eff    = sa_q & a_q[width_p-1];
    assign sb_eff    = sb_q & b_q[width_p-1];
    assign a_mag_d   = {{width_p{1'b0}}, sa_eff ? -a_q[width_p-1:0] : a_q[width_p-1:0]};
    assign b_mag_d   = sb_eff ? -b_q : b_q;
    assign b_shift_d = b_q >> bits_per_iter_p;
    assign cnt_d     = cnt_q + cnt_w_lp'(1);
    assign last_d    = (cnt_d == cnt_w_lp'(n_lp)) || ((early_exit_p != 0) && (b_shift_d == '0));

    assign ready_and_o = (state_q == IDLE);
    assign v_o         = (state_q == DONE);
    assign result_o    = hi_q ? acc_q[2*width_p-1:width_p] : acc_q[width_p-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (v_i) begin
                    a_q     <= {{width_p{1'b0}}, opA_i};
                    b_q     <= opB_i;
                    sa_q    <= signed_opA_i;
                    sb_q    <= signed_opB_i;
                    hi_q    <= gets_high_part_i;
                    acc_q   <= '0;
                    state_q <= NEG;
                end
                NEG: begin
                    a_q     <= a_mag_d;
                    b_q     <= b_mag_d;
                    neg_q   <= sa_eff ^ sb_eff;
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    acc_q   <= acc_q + pp;
                    a_q     <= a_q << bits_per_iter_p;
                    b_q     <= b_shift_d;
                    cnt_q   <= cnt_d;
                    state_q <= last_d ? NEG_R : CALC;
                end
                NEG_R: begin
                    acc_q   <= neg_q ? -acc_q : acc_q;
                    state_q <= DONE;
                end
                DONE: if (yumi_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_imul_iterative_radix.sv
// tb_bsg_imul_iterative_radix: directed checks of the iterative multiplier with and without early exit
module tb_bsg_imul_iterative_radix;

    logic        clk = 1'b0, rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, y0 = 1'b0, y1 = 1'b0;
    logic [31:0] opa = '0, opb = '0;
    logic        sa = 1'b0, sb = 1'b0, hi = 1'b0;
    logic        rdy0, rdy1, vo0, vo1;
    logic [31:0] res0, res1;
    int          errors = 0, checks = 0, lat;

    always #5 clk = ~clk;

    bsg_imul_iterative_radix #(.width_p(32), .bits_per_iter_p(4), .early_exit_p(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .v_i(v0), .ready_and_o(rdy0), .opA_i(opa), .opB_i(opb),
        .signed_opA_i(sa), .signed_opB_i(sb), .gets_high_part_i(hi),
        .v_o(vo0), .result_o(res0), .yumi_i(y0));

    bsg_imul_iterative_radix #(.width_p(32), .bits_per_iter_p(4), .early_exit_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .v_i(v1), .ready_and_o(rdy1), .opA_i(opa), .opB_i(opb),
        .signed_opA_i(sa), .signed_opB_i(sb), .gets_high_part_i(hi),
        .v_o(vo1), .result_o(res1), .yumi_i(y1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_vo(input int d);
        return d == 0 ? vo0 : vo1;
    endfunction

    function automatic logic get_rdy(input int d);
        return d == 0 ? rdy0 : rdy1;
    endfunction

    function automatic logic [31:0] get_res(input int d);
        return d == 0 ? res0 : res1;
    endfunction

    // Issue one request; lat is the cycle index (accept cycle = 0) at which v_o is first seen.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic s_a, input logic s_b, input logic h, output int c);
        @(negedge clk);
        opa = a; opb = b; sa = s_a; sb = s_b; hi = h;
        if (d == 0) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        c = 1;
        while (!get_vo(d) && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic pop(input int d);
        @(negedge clk);
        if (d == 0) y0 = 1'b1; else y1 = 1'b1;
        @(posedge clk);
        #1;
        y0 = 1'b0; y1 = 1'b0;
        check("ready_after_yumi", 64'(get_rdy(d)), 64'd1);
    endtask

    task automatic mul(input string tag, input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic s_a, input logic s_b, input logic h,
                       input logic [31:0] exp, input int exp_lat);
        int c;
        issue(d, a, b, s_a, s_b, h, c);
        check({tag, "_vo"}, 64'(get_vo(d)), 64'd1);
        check(tag, 64'(get_res(d)), 64'(exp));
        if (exp_lat > 0) check({tag, "_lat"}, 64'(c), 64'(exp_lat));
        pop(d);
    endtask

    initial begin
        #12;
        check("reset_ready", 64'(rdy0), 64'd1);
        check("reset_vo", 64'(vo0), 64'd0);
        check("reset_result", 64'(res0), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        mul("uu_ff_hi", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFE, 11);
        mul("uu_ff_lo", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'h00000001, 11);
        mul("mneg_x2_hi", 0, 32'h80000000, 32'h00000002, 1, 1, 1, 32'hFFFFFFFF, 11);
        mul("mneg_x2_lo", 0, 32'h80000000, 32'h00000002, 1, 1, 0, 32'h00000000, 11);
        mul("m1_u_hi", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 32'hFFFFFFFF, 0);
        mul("m1_u_lo", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 32'h00000001, 0);
        mul("early_lo", 1, 32'h12345678, 32'h00000003, 0, 0, 0, 32'h369D0368, 4);
        mul("mneg_sq_hi", 1, 32'h80000000, 32'h80000000, 1, 1, 1, 32'h40000000, 11);
        mul("mneg_sq_lo", 1, 32'h80000000, 32'h80000000, 1, 1, 0, 32'h00000000, 11);
        mul("zero_b_hi", 1, 32'hFFFFFFFB, 32'h00000000, 1, 1, 1, 32'h00000000, 4);
        mul("zero_a_lo", 1, 32'h00000000, 32'h00000005, 0, 0, 0, 32'h00000000, 4);
        mul("neg_lo", 1, 32'hFFFFFFFB, 32'h00000007, 1, 0, 0, 32'hFFFFFFDD, 0);

        issue(0, 32'd7, 32'd6, 0, 0, 0, lat);
        check("hold_vo", 64'(vo0), 64'd1);
        @(negedge clk);
        v0 = 1'b1;
        opa = 32'd100; opb = 32'd100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", 64'(res0), 64'd42);
            check("hold_ready", 64'(rdy0), 64'd0);
            check("hold_vo_stay", 64'(vo0), 64'd1);
        end
        @(negedge clk);
        y0 = 1'b1;
        @(posedge clk);
        #1;
        y0 = 1'b0;
        check("yumi_ready", 64'(rdy0), 64'd1);
        check("yumi_vo", 64'(vo0), 64'd0);
        @(negedge clk);
        v0 = 1'b0;

        @(negedge clk);
        opa = 32'h12345678; opb = 32'h9ABCDEF0; sa = 1'b0; sb = 1'b0; hi = 1'b1;
        v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midreset_ready", 64'(rdy0), 64'd1);
        check("midreset_vo", 64'(vo0), 64'd0);
        check("midreset_result", 64'(res0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mul("post_reset_lo", 0, 32'd7, 32'd6, 0, 0, 0, 32'd42, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_imul_iterative_radix.md
BSG_IMUL_ITERATIVE_RADIX -- requirements
Module: bsg_imul_iterative_radix

Interface
REQ-001 SHALL have parameter width_p, default 32, meaning operand/result width.
REQ-002 SHALL have parameter bits_per_iter_p, default 1, meaning multiplier bits retired per CALC cycle; width_p mod bits_per_iter_p == 0 (elaboration error otherwise).
REQ-003 SHALL have parameter early_exit_p, default 1, meaning 1 enables leaving CALC once remaining multiplier bits are zero.
REQ-004 SHALL have port clk_i input 1: sole clock, rising edge.
REQ-005 SHALL have port reset_i input 1: asynchronous, active-high reset.
REQ-006 SHALL have port v_i input 1: request valid.
REQ-007 SHALL have port ready_and_o output 1: idle, will accept request.
REQ-008 SHALL have ports opA_i and opB_i, input width_p each: multiplicand and multiplier.
REQ-009 SHALL have ports signed_opA_i and signed_opB_i, input 1 each: operand is two's complement.
REQ-010 SHALL have port gets_high_part_i input 1: return product bits [2W-1:W], else [W-1:0].
REQ-011 SHALL have port v_o output 1: result valid.
REQ-012 SHALL have port result_o output width_p: selected product half.
REQ-013 SHALL have port yumi_i input 1: consumer takes result; legal only while v_o=1.

Function
REQ-014 SHALL implement states IDLE, NEG, CALC, NEG_R, DONE; ready_and_o=1 only in IDLE, v_o=1 only in DONE.
REQ-015 SHALL latch operands and mode when v_i & ready_and_o, moving IDLE->NEG; v_i outside IDLE is ignored.
REQ-016 SHALL, in NEG (one cycle), replace each operand by its magnitude when its signed flag and MSB are both 1; need_neg = signA_eff XOR signB_eff.
REQ-017 SHALL keep a 2*width_p accumulator cleared on accept; each CALC cycle adds (A_shifted * low bits_per_iter_p bits of B) and then shifts A left and B right by bits_per_iter_p.
REQ-018 SHALL count CALC cycles with a counter of width clog2(N+1), N = width_p/bits_per_iter_p, cleared on NEG->CALC.
REQ-019 SHALL leave CALC for NEG_R after the Nth cycle, or earlier when early_exit_p=1 and the post-shift B is all zero; CALC lasts at least one cycle.
REQ-020 SHALL, in NEG_R (one cycle), two's-complement negate the full 2W accumulator if need_neg, else hold it.
REQ-021 SHALL drive result_o from the selected half of the accumulator; the value is stable for every DONE cycle.
REQ-022 SHALL leave DONE->IDLE on yumi_i; without yumi_i, remain in DONE indefinitely.
REQ-023 SHALL give latency, for acceptance at cycle 0: NEG in cycle 1, CALC from cycle 2 for K cycles (K=N without early exit), NEG_R in cycle K+2, v_o=1 from cycle K+3.
REQ-024 SHALL produce the exact result for every operand value, including the most-negative value times the most-negative value and zero operands.
REQ-025 SHALL ignore v_i in the yumi_i cycle; the next request is acceptable one cycle later in IDLE.

Reset
REQ-026 SHALL, on reset_i assertion at any time including mid-CALC, immediately force state IDLE, counter 0, accumulator 0, operands 0, flags 0.
REQ-027 SHALL, while reset_i is high, drive ready_and_o=1, v_o=0, result_o=0.

Structure
REQ-028 SHALL place the state enum and the helper for N/counter-width computation in shared package bsg_imul_pkg.
REQ-029 SHALL isolate the unsigned digit*multiplicand partial product in sub-module bsg_imul_radix_pp (params width_p, bits_per_iter_p).

Verification (width_p=32, bits_per_iter_p=4, N=8 unless noted)
REQ-030 SHALL cover: unsigned 0xFFFFFFFF*0xFFFFFFFF, early_exit_p=0 -> high=0xFFFFFFFE, low=0x00000001, v_o first at cycle 11.
REQ-031 SHALL cover: signed 0x80000000 * signed 0x00000002, high -> 0xFFFFFFFF; low -> 0x00000000.
REQ-032 SHALL cover: signed 0xFFFFFFFF (-1) * unsigned 0xFFFFFFFF, high -> 0xFFFFFFFF; low -> 0x00000001.
REQ-033 SHALL cover: early_exit_p=1, opA=0x12345678, opB=0x00000003, low -> 0x369D0368, exactly one CALC cycle, v_o at cycle 4.
REQ-034 SHALL cover: yumi_i held low 5 cycles in DONE with v_i=1 throughout -> result_o constant, ready_and_o=0, no new accept; after yumi_i, IDLE with ready_and_o=1 next cycle.
REQ-035 SHALL cover: reset_i pulsed in the third CALC cycle -> same-cycle ready_and_o=1, v_o=0, result_o=0; a following request 7*6 low -> 42.
